// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding
// and the quotient value reported on a divide by zero.
package div_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest operand the divider supports; the divide-by-zero quotient is
    // taken as the low W bits of this all-ones constant.
    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] DBZ_QUOTIENT_ALL = '1;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle of the sequential divider. The requester drives
// start and the operands; the divider returns status and results.
interface div_seq_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_seq_sub_rc.sv
// Ripple-carry subtractor a - b, formed as a + ~b + 1 from a chain of
// single-bit full adders. cout=1 means the subtraction did not borrow.

// One-bit full adder cell.
module FA1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module sub_rc #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         cout
);
    logic [N:0] carry;

    // The +1 of the two's complement enters as the chain's carry-in.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        FA1 u_fa (
            .a   (a[i]),
            .b   (~b[i]),
            .cin (carry[i]),
            .s   (diff[i]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[N];
endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring unsigned divider: one quotient bit per clock by
// trial subtraction of the divisor from a shifted partial remainder.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    localparam int CW = $clog2(W);

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  count;
    logic [W:0]     p;
    logic [W-1:0]   q;
    logic [W-1:0]   divisor_r;
    logic [W-1:0]   quotient_r;
    logic [W-1:0]   remainder_r;
    logic           dbz_r;

    logic [W:0]     s;
    logic [W:0]     t;
    logic           no_borrow;
    logic [W:0]     p_next;
    logic [W-1:0]   q_next;
    logic           last_iter;
    logic           st_ready;
    logic           st_busy;
    logic           st_done;
    logic           unused_p_msb;

    // The restored remainder is always below the divisor, so P's top bit
    // never carries information into the next step.
    assign unused_p_msb = p[W];

    assign s         = {p[W-1:0], q[W-1]};
    assign last_iter = (count == CW'(W - 1));

    sub_rc #(
        .N(W + 1)
    ) u_sub (
        .a   (s),
        .b   ({1'b0, divisor_r}),
        .diff(t),
        .cout(no_borrow)
    );

    // Keep the difference when the trial did not borrow, else restore.
    always_comb begin
        p_next = s;
        q_next = {q[W-2:0], 1'b0};
        if (no_borrow) begin
            p_next = t;
            q_next = {q[W-2:0], 1'b1};
        end
    end

    // Next-state and status decode for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_next = state;
        st_ready   = 1'b0;
        st_busy    = 1'b0;
        st_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                st_ready = 1'b1;
                if (bus.start) begin
                    state_next = (bus.divisor == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                st_busy = 1'b1;
                if (last_iter) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                st_done    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, iteration datapath and result registers; results
    // are loaded on the edge entering DONE so they are valid with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            p           <= '0;
            q           <= '0;
            divisor_r   <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        divisor_r <= bus.divisor;
                        count     <= '0;
                        p         <= '0;
                        q         <= bus.dividend;
                        dbz_r     <= 1'b0;
                        if (bus.divisor == '0) begin
                            quotient_r  <= DBZ_QUOTIENT_ALL[W-1:0];
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    p     <= p_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        quotient_r  <= q_next;
                        remainder_r <= p_next[W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready       = st_ready;
    assign bus.busy        = st_busy;
    assign bus.done        = st_done;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule
